// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: shared types and constants for the multi-cycle MIPS main
// controller (main_fsm_m) and its wait-timer sub-module.
//   state_t      - controller state encoding
//   OP_*         - 6-bit opcode values of IR[31:26]
//   SRCB_*       - alu_src_b select encodings
//   ALUOP_*      - alu_op encodings
//   PCSRC_*      - pc_src select encodings
package main_fsm_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXECUTE,
        ST_ALUWB,
        ST_BRANCH,
        ST_ADDIEX,
        ST_ADDIWB,
        ST_JUMP,
        ST_ERROR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory handshake and are watched by the timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/main_fsm_m_wait_timer.sv
// wait_timer_m: saturating wait counter for the memory-ready watchdog.
//   clk_i     - clock, rising edge
//   rst_ni    - asynchronous active-low reset
//   clear_i   - return the count to zero
//   inc_i     - one more not-ready cycle
//   expired_o - this increment makes the count reach all-ones
module wait_timer_m #(
    parameter int unsigned W = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [W-1:0] LAST = W'((1 << W) - 2);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Fires combinationally on the increment that would land on all-ones,
    // so the controller leaves for ERROR on that same edge.
    assign expired_o = inc_i && !clear_i && (count_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/main_fsm_m.sv
// main_fsm_m: multi-cycle MIPS main controller with memory-ready handshake
// and timeout watchdog.
// Optional feature macro: MAIN_FSM_BNE_EN (adds bne via the BRANCH state).
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   opcode      - IR[31:26], held stable by IR after fetch
//   mem_ready   - memory access completes this cycle
//   iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, alu_op, pc_src, branch, branch_ne, pc_write
//               - datapath controls, decoded from the current state
//   illegal_op  - one-cycle pulse in DECODE on an undecodable opcode
//   mem_timeout - sticky watchdog error flag
module main_fsm_m
    import main_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 4,
    parameter int unsigned OP_W      = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            iord,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic            branch,
    output logic            branch_ne,
    output logic            pc_write,
    output logic            illegal_op,
    output logic            mem_timeout
);

    state_t     state_q;
    state_t     state_d;
    logic       mem_timeout_q;
    logic [5:0] op;
    logic       op_legal;
    logic       wt_inc;
    logic       wt_clear;
    logic       wt_expired;

    assign op = 6'(opcode);

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef MAIN_FSM_BNE_EN
            OP_BNE:                                        op_legal = 1'b1;
`endif
            default:                                       op_legal = 1'b0;
        endcase
    end

    // The count only advances while stalled in a wait state; any other cycle
    // (ready, or a non-wait state) clears it, which covers every state change.
    assign wt_inc   = is_wait_state(state_q) && !mem_ready;
    assign wt_clear = !wt_inc;

    wait_timer_m #(
        .W(TIMEOUT_W)
    ) u_wait_timer (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clear_i  (wt_clear),
        .inc_i    (wt_inc),
        .expired_o(wt_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (wt_expired)     state_d = ST_ERROR;
                else if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!op_legal) begin
                    state_d = ST_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = ST_MEMADR;
                        OP_RTYPE:     state_d = ST_EXECUTE;
                        OP_ADDI:      state_d = ST_ADDIEX;
                        OP_J:         state_d = ST_JUMP;
                        default:      state_d = ST_BRANCH;
                    endcase
                end
            end
            ST_MEMADR:  state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD: begin
                if (wt_expired)     state_d = ST_ERROR;
                else if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB:   state_d = ST_FETCH;
            ST_MEMWR: begin
                if (wt_expired)     state_d = ST_ERROR;
                else if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXECUTE: state_d = ST_ALUWB;
            ST_ALUWB:   state_d = ST_FETCH;
            ST_BRANCH:  state_d = ST_FETCH;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            ST_ADDIWB:  state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            ST_ERROR:   state_d = ST_ERROR;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_FETCH;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_ERROR) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_write   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            ST_FETCH: begin
                alu_src_b = SRCB_FOUR;
                // Reset forces FETCH; the rst term keeps the fetch strobes
                // quiet while reset is held even if mem_ready is high.
                ir_write  = mem_ready && rst;
                pc_write  = mem_ready && rst;
            end
            ST_DECODE: begin
                alu_src_b  = SRCB_IMM_SH2;
                illegal_op = !op_legal;
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                iord = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
`ifdef MAIN_FSM_BNE_EN
                branch    = (op != OP_BNE);
                branch_ne = (op == OP_BNE);
`else
                branch    = 1'b1;
`endif
            end
            ST_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_ADDIWB: begin
                reg_write = 1'b1;
            end
            ST_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_timeout = mem_timeout_q;

endmodule
